// File: rtl/msdap_pkg.sv
// Shared MSDAP definitions: sample width, zero threshold, receiver states.
// Also used by MSDAP_controller and the ALU.
package msdap_pkg;

    localparam int WORD_W      = 16;
    localparam int ZERO_THRESH = 800;
    localparam int ZC_W        = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/msdap_zero_detect.sv
// Per-channel zero-run detector: saturating count of consecutive zero words.
// Flag is high while the count sits at ZERO_THRESH.
module msdap_zero_detect #(
    parameter int WORD_W      = msdap_pkg::WORD_W,
    parameter int ZERO_THRESH = msdap_pkg::ZERO_THRESH,
    parameter int ZC_W        = msdap_pkg::ZC_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [WORD_W-1:0] word_i,
    input  logic              word_valid_i,
    input  logic              clear_i,
    output logic              zero_o
);

    localparam logic [ZC_W-1:0] THR = ZC_W'(ZERO_THRESH);

    logic [ZC_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (word_valid_i) begin
            if (word_i == '0) begin
                if (cnt_q != THR) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == THR);

endmodule

// File: rtl/msdap_serial_receiver.sv
// MSDAP serial front end: framed MSB-first L/R deserialiser with zero flags.
// Define MSDAP_FRAME_ERR_EN to add the sticky frame_err output.
module msdap_serial_receiver #(
    parameter int WORD_W      = msdap_pkg::WORD_W,
    parameter int ZERO_THRESH = msdap_pkg::ZERO_THRESH,
    parameter int ZC_W        = msdap_pkg::ZC_W
) (
    input  logic              Dclk,
    input  logic              Reset_n,
    input  logic              Frame,
    input  logic              InputL,
    input  logic              InputR,
    input  logic              Clear,
    output logic [WORD_W-1:0] data_L,
    output logic [WORD_W-1:0] data_R,
    output logic              input_rdy_flag,
    output logic              zero_flag_L,
    output logic              zero_flag_R
`ifdef MSDAP_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);

    import msdap_pkg::*;

    localparam int              CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-2:0] shl_q, shl_d;
    logic [WORD_W-2:0] shr_q, shr_d;
    logic [WORD_W-1:0] dl_q, dl_d;
    logic [WORD_W-1:0] dr_q, dr_d;
    logic              rdy_q, rdy_d;
    logic              done;
    logic [WORD_W-1:0] word_l, word_r;
    logic [WORD_W-2:0] msb_l, msb_r;

    // Shift registers hold the upper bits; the final bit joins combinationally.
    assign word_l = {shl_q, InputL};
    assign word_r = {shr_q, InputR};
    assign msb_l  = {{(WORD_W-2){1'b0}}, InputL};
    assign msb_r  = {{(WORD_W-2){1'b0}}, InputR};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shl_d   = shl_q;
        shr_d   = shr_q;
        dl_d    = dl_q;
        dr_d    = dr_q;
        rdy_d   = 1'b0;
        done    = 1'b0;
        if (Clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Frame) begin
                        state_d = SHIFT;
                        cnt_d   = CNT_W'(1);
                        shl_d   = msb_l;
                        shr_d   = msb_r;
                    end
                end
                SHIFT: begin
                    if (Frame) begin
                        cnt_d = CNT_W'(1);
                        shl_d = msb_l;
                        shr_d = msb_r;
                    end else if (cnt_q == LAST) begin
                        done    = 1'b1;
                        rdy_d   = 1'b1;
                        dl_d    = word_l;
                        dr_d    = word_r;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        shl_d = {shl_q[WORD_W-3:0], InputL};
                        shr_d = {shr_q[WORD_W-3:0], InputR};
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Dclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shl_q   <= '0;
            shr_q   <= '0;
            dl_q    <= '0;
            dr_q    <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shl_q   <= shl_d;
            shr_q   <= shr_d;
            dl_q    <= dl_d;
            dr_q    <= dr_d;
            rdy_q   <= rdy_d;
        end
    end

    assign data_L         = dl_q;
    assign data_R         = dr_q;
    assign input_rdy_flag = rdy_q;

    msdap_zero_detect #(
        .WORD_W      (WORD_W),
        .ZERO_THRESH (ZERO_THRESH),
        .ZC_W        (ZC_W)
    ) u_zd_l (
        .clk_i        (Dclk),
        .rst_ni       (Reset_n),
        .word_i       (word_l),
        .word_valid_i (done),
        .clear_i      (Clear),
        .zero_o       (zero_flag_L)
    );

    msdap_zero_detect #(
        .WORD_W      (WORD_W),
        .ZERO_THRESH (ZERO_THRESH),
        .ZC_W        (ZC_W)
    ) u_zd_r (
        .clk_i        (Dclk),
        .rst_ni       (Reset_n),
        .word_i       (word_r),
        .word_valid_i (done),
        .clear_i      (Clear),
        .zero_o       (zero_flag_R)
    );

`ifdef MSDAP_FRAME_ERR_EN
    logic err_q, err_d, resync;

    assign resync = (state_q == SHIFT) && Frame;

    always_comb begin
        err_d = err_q;
        if (Clear) begin
            err_d = 1'b0;
        end else if (resync) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge Dclk or negedge Reset_n) begin
        if (!Reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign frame_err = err_q;
`endif

endmodule

// File: tb/tb_msdap_serial_receiver.sv
// Scoreboard bench for msdap_serial_receiver: directed serial words,
// expected strobes queued by the driver and checked by a monitor.
module tb_msdap_serial_receiver;

    logic        Dclk = 1'b0;
    logic        Reset_n;
    logic        Frame;
    logic        InputL;
    logic        InputR;
    logic        Clear;
    logic [15:0] data_L;
    logic [15:0] data_R;
    logic        input_rdy_flag;
    logic        zero_flag_L;
    logic        zero_flag_R;
`ifdef MSDAP_FRAME_ERR_EN
    logic        frame_err;
`endif

    msdap_serial_receiver dut (
        .Dclk           (Dclk),
        .Reset_n        (Reset_n),
        .Frame          (Frame),
        .InputL         (InputL),
        .InputR         (InputR),
        .Clear          (Clear),
        .data_L         (data_L),
        .data_R         (data_R),
        .input_rdy_flag (input_rdy_flag),
        .zero_flag_L    (zero_flag_L),
        .zero_flag_R    (zero_flag_R)
`ifdef MSDAP_FRAME_ERR_EN
        ,
        .frame_err      (frame_err)
`endif
    );

    always #5 Dclk = ~Dclk;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        zl;
        logic        zr;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   zl_n   = 0;
    int   zr_n   = 0;
    logic prev_rdy = 1'b0;

    always @(posedge Dclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        zl_n = 0;
        zr_n = 0;
    endtask

    // Called on the Frame bit; strobe appears 16 edges later.
    task automatic push(input logic [15:0] l, input logic [15:0] r);
        exp_t e;
        zl_n = (l == 16'h0) ? ((zl_n < 800) ? zl_n + 1 : 800) : 0;
        zr_n = (r == 16'h0) ? ((zr_n < 800) ? zr_n + 1 : 800) : 0;
        e.l   = l;
        e.r   = r;
        e.zl  = (zl_n >= 800);
        e.zr  = (zr_n >= 800);
        e.cyc = cyc + 16;
        sb.push_back(e);
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        for (int i = 0; i < 16; i++) begin
            @(negedge Dclk);
            Frame  = (i == 0);
            InputL = l[15-i];
            InputR = r[15-i];
            if (i == 0) push(l, r);
        end
    endtask

    task automatic partial(input int n, input logic [15:0] l,
                           input logic [15:0] r);
        for (int i = 0; i < n; i++) begin
            @(negedge Dclk);
            Frame  = (i == 0);
            InputL = l[15-i];
            InputR = r[15-i];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Dclk);
            Frame  = 1'b0;
            InputL = 1'($urandom_range(0, 1));
            InputR = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic pulse_clear();
        @(negedge Dclk);
        Frame = 1'b0;
        Clear = 1'b1;
        @(negedge Dclk);
        Clear = 1'b0;
        model_clear();
    endtask

    always @(negedge Dclk) begin
        if (Reset_n) begin
            if (input_rdy_flag) begin
                if (prev_rdy) chk("rdy_one_cycle", 32'd1, 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("data_L", 32'(data_L), 32'(e.l));
                    chk("data_R", 32'(data_R), 32'(e.r));
                    chk("zero_flag_L", 32'(zero_flag_L), 32'(e.zl));
                    chk("zero_flag_R", 32'(zero_flag_R), 32'(e.zr));
                    chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            prev_rdy = input_rdy_flag;
        end else begin
            prev_rdy = 1'b0;
        end
    end

    task automatic check_reset_vals();
        chk("rst_data_L", 32'(data_L), 32'd0);
        chk("rst_data_R", 32'(data_R), 32'd0);
        chk("rst_rdy", 32'(input_rdy_flag), 32'd0);
        chk("rst_zfL", 32'(zero_flag_L), 32'd0);
        chk("rst_zfR", 32'(zero_flag_R), 32'd0);
`ifdef MSDAP_FRAME_ERR_EN
        chk("rst_frame_err", 32'(frame_err), 32'd0);
`endif
    endtask

    initial begin
        Reset_n = 1'b1;
        Frame   = 1'b0;
        InputL  = 1'b0;
        InputR  = 1'b0;
        Clear   = 1'b0;
        #2 Reset_n = 1'b0;
        #1 check_reset_vals();
        idle(2);
        Reset_n = 1'b1;
        idle(3);

        send(16'hA5C3, 16'h0F01);
        idle(4);

        send(16'h0001, 16'h8001);
        send(16'h0002, 16'h8002);
        send(16'h0003, 16'h8003);
        idle(4);

`ifdef MSDAP_FRAME_ERR_EN
        chk("frame_err_before", 32'(frame_err), 32'd0);
`endif
        partial(7, 16'hBEEF, 16'hDEAD);
        send(16'h1234, 16'h5678);
        idle(4);
`ifdef MSDAP_FRAME_ERR_EN
        chk("frame_err_set", 32'(frame_err), 32'd1);
        idle(3);
        chk("frame_err_sticky", 32'(frame_err), 32'd1);
        pulse_clear();
        chk("frame_err_clr", 32'(frame_err), 32'd0);
`else
        pulse_clear();
`endif

        for (int w = 0; w < 800; w++) send(16'h0000, 16'h00FF);
        idle(3);
        chk("zfL_after_800", 32'(zero_flag_L), 32'd1);
        send(16'h0001, 16'h00FF);
        idle(3);
        chk("zfL_after_801", 32'(zero_flag_L), 32'd0);
        chk("zfR_stays_0", 32'(zero_flag_R), 32'd0);

        // Clear and Frame on the same edge: word must be ignored.
        @(negedge Dclk);
        Clear  = 1'b1;
        Frame  = 1'b1;
        InputL = 1'b1;
        InputR = 1'b1;
        @(negedge Dclk);
        Clear = 1'b0;
        model_clear();
        for (int i = 0; i < 15; i++) begin
            Frame  = 1'b0;
            InputL = 1'b1;
            InputR = 1'b1;
            @(negedge Dclk);
        end
        idle(4);
        chk("clear_hold_L", 32'(data_L), 32'h0001);
        chk("clear_hold_R", 32'(data_R), 32'h00FF);

        for (int w = 0; w < 799; w++) send(16'h0000, 16'h0000);
        idle(3);
        pulse_clear();
        send(16'h0000, 16'h0000);
        idle(3);
        chk("zfL_after_clear", 32'(zero_flag_L), 32'd0);
        chk("zfR_after_clear", 32'(zero_flag_R), 32'd0);

        send(16'hC001, 16'h3C3C);
        idle(3);
        partial(8, 16'hFFFF, 16'hFFFF);
        @(negedge Dclk);
        Frame   = 1'b0;
        Reset_n = 1'b0;
        model_clear();
        #1 check_reset_vals();
        idle(2);
        Reset_n = 1'b1;
        idle(20);
        chk("no_strobe_after_rst", 32'(data_L), 32'd0);
        send(16'hFFFF, 16'hFFFF);
        idle(20);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
